// File: rtl/pipe_ctrl.sv
// pipe_ctrl: N-stage stall/flush/redirect controller with stall watchdog.
// Optional perf counters enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int NUM_STAGES    = 6,
  parameter int SW            = $clog2(NUM_STAGES),
  parameter int STALL_TIMEOUT = 1024,
  parameter int CNT_W         = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_STAGES-1:0] stallreq,
  input  logic                  flush_req,
  input  logic [SW-1:0]         flush_stage,
  input  logic [31:0]           flush_pc,
  output logic [NUM_STAGES-1:0] stall,
  output logic [NUM_STAGES-1:0] bubble,
  output logic [NUM_STAGES-1:0] flush,
  output logic                  redirect_valid,
  output logic [31:0]           redirect_pc,
  output logic                  stall_timeout,
  output logic [CNT_W-1:0]      perf_stall_cycles,
  output logic [CNT_W-1:0]      perf_flush_count
);
  typedef enum logic {RUN, FLUSH} state_t;
  state_t                state_q, state_d;
  logic [NUM_STAGES-1:0] flush_q, flush_d, eff, fmask;
  logic                  redirect_valid_q, redirect_valid_d;
  logic [31:0]           redirect_pc_q, redirect_pc_d;
  logic                  stall_timeout_q, stall_timeout_d;
  logic [CNT_W-1:0]      wd_q, wd_d;
  logic [SW-1:0]         s_c;
  logic                  stall_any;
  always_comb begin
    s_c = (int'(flush_stage) >= NUM_STAGES) ? SW'(NUM_STAGES - 1) : flush_stage;
    fmask = '0;
    for (int k = 0; k < NUM_STAGES; k++) fmask[k] = (k <= int'(s_c));
  end
  // Flushed stages ignore their own hold requests during the flush cycle.
  always_comb begin
    eff = stallreq & ~((state_q == FLUSH) ? flush_q : '0);
    stall = '0;
    bubble = '0;
    for (int k = 0; k < NUM_STAGES; k++) stall[k] = |(eff >> k);
    for (int k = 0; k < NUM_STAGES - 1; k++) bubble[k] = stall[k] & ~stall[k+1];
  end
  always_comb begin
    state_d          = flush_req ? FLUSH : RUN;
    flush_d          = flush_req ? fmask : '0;
    redirect_valid_d = flush_req;
    redirect_pc_d    = flush_req ? flush_pc : redirect_pc_q;
    stall_any        = |stall;
    wd_d             = stall_any ? ((&wd_q) ? wd_q : wd_q + 1'b1) : '0;
    stall_timeout_d  = stall_timeout_q | (stall_any && wd_q >= CNT_W'(STALL_TIMEOUT - 1));
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= RUN;
      flush_q          <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      stall_timeout_q  <= 1'b0;
      wd_q             <= '0;
    end else begin
      state_q          <= state_d;
      flush_q          <= flush_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      stall_timeout_q  <= stall_timeout_d;
      wd_q             <= wd_d;
    end
  end
  assign flush          = flush_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign stall_timeout  = stall_timeout_q;
`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] psc_q, psc_d, pfc_q, pfc_d;
  always_comb begin
    psc_d = (stall_any && !(&psc_q)) ? psc_q + 1'b1 : psc_q;
    pfc_d = (state_q == FLUSH && !(&pfc_q)) ? pfc_q + 1'b1 : pfc_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      psc_q <= '0;
      pfc_q <= '0;
    end else begin
      psc_q <= psc_d;
      pfc_q <= pfc_d;
    end
  end
  assign perf_stall_cycles = psc_q;
  assign perf_flush_count  = pfc_q;
`else
  assign perf_stall_cycles = '0;
  assign perf_flush_count  = '0;
`endif
endmodule
